// File: rtl/cpu_pkg.sv
// Shared definitions for the VeriRisc instruction sequencer: opcodes,
// sequencer state encoding, the control-bundle struct and the ALU-op decode.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // The low three bits of the eight working states equal the phase index.
    typedef enum logic [3:0] {
        ST_INST_ADDR  = 4'd0,
        ST_INST_FETCH = 4'd1,
        ST_INST_LOAD  = 4'd2,
        ST_IDLE       = 4'd3,
        ST_OP_ADDR    = 4'd4,
        ST_OP_FETCH   = 4'd5,
        ST_ALU_OP     = 4'd6,
        ST_STORE      = 4'd7,
        ST_HALTED     = 4'd8
    } cpu_state_t;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic wr;
        logic data_e;
        logic halt;
    } cpu_ctrl_t;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Signal bundle between the sequencer and the CPU datapath.
// There is no valid/ready handshake here: every control is a level that is
// valid for the whole cycle in which the sequencer asserts it, and opcode/zero/run
// are plain levels sampled by the sequencer every cycle.
interface cpu_controller_if #(
    parameter int CNT_WIDTH = 16
);
    import cpu_pkg::*;

    logic [2:0]           opcode;
    logic                 zero;
    logic                 run;
    logic                 sel;
    logic                 rd;
    logic                 ld_ir;
    logic                 inc_pc;
    logic                 ld_pc;
    logic                 ld_ac;
    logic                 wr;
    logic                 data_e;
    logic                 halt;
    logic [2:0]           phase;
    logic [CNT_WIDTH-1:0] instr_cnt;
    cpu_state_t           dbg_state;

    // Sequencer side.
    modport master (
        input  opcode, zero, run,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt,
        output phase, instr_cnt, dbg_state
    );

    // Datapath side.
    modport slave (
        output opcode, zero, run,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt,
        input  phase, instr_cnt, dbg_state
    );

endinterface

// File: rtl/cpu_controller_counter.sv
// Generic loadable up-counter with synchronous active-high reset; load wins
// over enable, count wraps modulo 2^WIDTH.
module cpu_controller_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_cnt_in,
    input  logic             i_enab,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Count register: reset, then load, then increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_cnt_in;
        end else if (i_enab) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_controller.sv
// VeriRisc instruction sequencer: eight phases per instruction plus HALTED.
// Controls are decoded combinationally from the registered state and the
// live opcode/zero inputs; a retire strobe advances the instruction counter.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    cpu_controller_if.master bus
);

    cpu_state_t r_state;
    cpu_state_t w_next_state;
    cpu_ctrl_t  w_ctrl;
    logic       w_is_hlt;
    logic       w_aluop;
    logic       w_retire;

    assign w_is_hlt = (bus.opcode == OP_HLT);
    assign w_aluop  = is_aluop(bus.opcode);

    // State register; reset overrides everything, including HALTED.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INST_ADDR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: linear walk through the phases, HLT diverts to HALTED.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INST_ADDR:  w_next_state = ST_INST_FETCH;
            ST_INST_FETCH: w_next_state = ST_INST_LOAD;
            ST_INST_LOAD:  w_next_state = ST_IDLE;
            ST_IDLE:       w_next_state = ST_OP_ADDR;
            ST_OP_ADDR:    w_next_state = w_is_hlt ? ST_HALTED : ST_OP_FETCH;
            ST_OP_FETCH:   w_next_state = ST_ALU_OP;
            ST_ALU_OP:     w_next_state = ST_STORE;
            ST_STORE:      w_next_state = ST_INST_ADDR;
            ST_HALTED:     w_next_state = bus.run ? ST_INST_ADDR : ST_HALTED;
            default:       w_next_state = ST_INST_ADDR;
        endcase
    end

    // Output decode; every control not named in a state stays low.
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            ST_INST_ADDR: begin
                w_ctrl.sel = 1'b1;
            end
            ST_INST_FETCH: begin
                w_ctrl.sel = 1'b1;
                w_ctrl.rd  = 1'b1;
            end
            ST_INST_LOAD, ST_IDLE: begin
                w_ctrl.sel   = 1'b1;
                w_ctrl.rd    = 1'b1;
                w_ctrl.ld_ir = 1'b1;
            end
            ST_OP_ADDR: begin
                w_ctrl.inc_pc = 1'b1;
                w_ctrl.halt   = w_is_hlt;
            end
            ST_OP_FETCH: begin
                w_ctrl.rd = w_aluop;
            end
            ST_ALU_OP: begin
                w_ctrl.rd     = w_aluop;
                w_ctrl.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
                w_ctrl.ld_pc  = (bus.opcode == OP_JMP);
                w_ctrl.data_e = (bus.opcode == OP_STO);
            end
            ST_STORE: begin
                // JMP raises both inc_pc and ld_pc; the PC resolves it as a load.
                w_ctrl.rd     = w_aluop;
                w_ctrl.ld_ac  = w_aluop;
                w_ctrl.inc_pc = (bus.opcode == OP_JMP);
                w_ctrl.ld_pc  = (bus.opcode == OP_JMP);
                w_ctrl.wr     = (bus.opcode == OP_STO);
                w_ctrl.data_e = (bus.opcode == OP_STO);
            end
            ST_HALTED: begin
                w_ctrl.halt = 1'b1;
            end
            default: begin
                w_ctrl = '0;
            end
        endcase
    end

    // An instruction retires on leaving STORE or on halting from OP_ADDR.
    assign w_retire = (r_state == ST_STORE) || ((r_state == ST_OP_ADDR) && w_is_hlt);

    cpu_controller_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_instr_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_load   (1'b0),
        .i_cnt_in ({CNT_WIDTH{1'b0}}),
        .i_enab   (w_retire),
        .o_cnt    (bus.instr_cnt)
    );

    assign bus.sel       = w_ctrl.sel;
    assign bus.rd        = w_ctrl.rd;
    assign bus.ld_ir     = w_ctrl.ld_ir;
    assign bus.inc_pc    = w_ctrl.inc_pc;
    assign bus.ld_pc     = w_ctrl.ld_pc;
    assign bus.ld_ac     = w_ctrl.ld_ac;
    assign bus.wr        = w_ctrl.wr;
    assign bus.data_e    = w_ctrl.data_e;
    assign bus.halt      = w_ctrl.halt;
    assign bus.phase     = (r_state == ST_HALTED) ? 3'd7 : r_state[2:0];
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed phases, HLT/run, reset
// cases, counter wrap, then random opcode/zero/run/rst against a phase model.
module tb_cpu_controller;
    import cpu_pkg::*;

    localparam int CW = 8;

    logic clk;
    logic rst;

    cpu_controller_if #(.CNT_WIDTH(CW)) bus ();

    cpu_controller #(.CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: phase 0..7 or 8 for halted, and retired count.
    int          m_p;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (phase model %0d)", tag, obs, exp, m_p);
        end
    endtask

    // Compare every DUT output with what the instruction rules require now.
    task automatic check_all();
        logic [2:0] op;
        logic       z;
        logic       alu;
        op  = bus.opcode;
        z   = bus.zero;
        alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        check("sel",    32'(bus.sel),    32'(m_p <= 3));
        check("rd",     32'(bus.rd),     32'((m_p >= 1 && m_p <= 3) || (m_p >= 5 && m_p <= 7 && alu)));
        check("ld_ir",  32'(bus.ld_ir),  32'(m_p == 2 || m_p == 3));
        check("inc_pc", 32'(bus.inc_pc), 32'(m_p == 4 || (m_p == 6 && op == OP_SKZ && z) || (m_p == 7 && op == OP_JMP)));
        check("ld_pc",  32'(bus.ld_pc),  32'((m_p == 6 || m_p == 7) && op == OP_JMP));
        check("ld_ac",  32'(bus.ld_ac),  32'(m_p == 7 && alu));
        check("wr",     32'(bus.wr),     32'(m_p == 7 && op == OP_STO));
        check("data_e", 32'(bus.data_e), 32'((m_p == 6 || m_p == 7) && op == OP_STO));
        check("halt",   32'(bus.halt),   32'(m_p == 8 || (m_p == 4 && op == OP_HLT)));
        check("phase",  32'(bus.phase),  (m_p == 8) ? 32'd7 : 32'(m_p));
        check("state",  32'(bus.dbg_state), 32'(m_p));
        check("instr_cnt", 32'(bus.instr_cnt), 32'(m_cnt % (1 << CW)));
    endtask

    // Apply inputs, check combinational outputs, then take one clock edge.
    task automatic cycle(input logic [2:0] op, input logic z, input logic rn, input logic r);
        bus.opcode = op;
        bus.zero   = z;
        bus.run    = rn;
        rst        = r;
        #1;
        check_all();
        @(posedge clk);
        if (r) begin
            m_p   = 0;
            m_cnt = 0;
        end else if (m_p == 8) begin
            if (rn) m_p = 0;
        end else if (m_p == 4 && op == OP_HLT) begin
            m_p   = 8;
            m_cnt = (m_cnt + 1) % (1 << CW);
        end else if (m_p == 7) begin
            m_p   = 0;
            m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
            m_p = m_p + 1;
        end
        #1;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z);
        for (int i = 0; i < 8; i++) cycle(op, z, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_p        = 0;
        m_cnt      = 0;
        rst        = 1'b1;
        bus.opcode = OP_ADD;
        bus.zero   = 1'b0;
        bus.run    = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two clocks, then ADD instructions.
        cycle(OP_ADD, 1'b0, 1'b0, 1'b1);
        cycle(OP_ADD, 1'b0, 1'b0, 1'b1);
        check("reset_phase", 32'(bus.phase), 32'd0);
        check("reset_sel", 32'(bus.sel), 32'd1);
        run_instr(OP_ADD, 1'b0);
        check("add_cnt", 32'(bus.instr_cnt), 32'd1);
        run_instr(OP_ADD, 1'b1);

        // SKZ both ways, JMP, STO, remaining ALU ops.
        run_instr(OP_SKZ, 1'b1);
        run_instr(OP_SKZ, 1'b0);
        run_instr(OP_JMP, 1'b0);
        run_instr(OP_STO, 1'b1);
        run_instr(OP_AND, 1'b0);
        run_instr(OP_XOR, 1'b1);
        run_instr(OP_LDA, 1'b0);

        // HLT: five halted clocks with run low, then one run pulse.
        for (int i = 0; i < 5; i++) cycle(OP_HLT, 1'b0, 1'b0, 1'b0);
        check("hlt_entered", 32'(bus.halt), 32'd1);
        for (int i = 0; i < 5; i++) cycle(OP_HLT, 1'b0, 1'b0, 1'b0);
        cycle(OP_HLT, 1'b0, 1'b1, 1'b0);
        check("resume_phase", 32'(bus.phase), 32'd0);
        check("hlt_cnt", 32'(bus.instr_cnt), 32'd10);

        // run held high through HLT, then run high with no effect outside HALTED.
        for (int i = 0; i < 6; i++) cycle(OP_HLT, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(OP_ADD, 1'b0, 1'b1, 1'b0);

        // Reset in phase 5, and while halted.
        for (int i = 0; i < 5; i++) cycle(OP_ADD, 1'b0, 1'b0, 1'b0);
        cycle(OP_ADD, 1'b0, 1'b1, 1'b1);
        check("rst_mid_cnt", 32'(bus.instr_cnt), 32'd0);
        for (int i = 0; i < 7; i++) cycle(OP_HLT, 1'b0, 1'b0, 1'b0);
        cycle(OP_HLT, 1'b0, 1'b1, 1'b1);
        check("rst_halt_phase", 32'(bus.phase), 32'd0);
        check("rst_halt_halt", 32'(bus.halt), 32'd0);

        // Counter wrap using short HLT/run instructions.
        begin
            int guard;
            guard = 0;
            while (m_cnt != (1 << CW) - 1 && guard < 4000) begin
                cycle(OP_HLT, 1'b0, 1'b1, 1'b0);
                guard++;
            end
            check("wrap_reach", 32'(bus.instr_cnt), 32'((1 << CW) - 1));
            guard = 0;
            while (m_cnt != 0 && guard < 20) begin
                cycle(OP_HLT, 1'b0, 1'b1, 1'b0);
                guard++;
            end
            check("wrap_zero", 32'(bus.instr_cnt), 32'd0);
        end

        // Random opcode/zero/run with occasional reset.
        for (int i = 0; i < 600; i++) begin
            cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 60) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
